btb_predict_ctrl: RTL

Branch prediction controller: the initiator side of the branch target buffer interface, driving its `tb` modport. It performs a zero-latency BTB lookup for the fetch PC and produces the predicted-taken flag and target. It also queues branch resolutions from the execute stage and applies each one as a read-modify-write of the BTB frame, updating a 2-bit saturating counter. It sits between fetch, the hazard unit and the BTB storage block.

---
 rtl/btb_predict_ctrl_if.sv | 25 ++
 rtl/btb_predict_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/btb_predict_ctrl_if.sv
// Branch target buffer port bundle: one combinational read port, one write port.
// Frame layout is {valid, tag, target[31:0], ctr[1:0]}.
interface btb_predict_ctrl_if #(
  parameter int IDX_W = 4
);
  localparam int TAG_W = 30 - IDX_W;
  localparam int FRM_W = 1 + TAG_W + 32 + 2;

  logic [IDX_W-1:0] rsel;
  logic [IDX_W-1:0] wsel;
  logic             wen;
  logic [FRM_W-1:0] wdat;
  logic [FRM_W-1:0] rdat;
  logic             phit;

  modport tb (
    output rsel, wsel, wen, wdat, phit,
    input  rdat
  );

  modport btb (
    input  rsel, wsel, wen, wdat, phit,
    output rdat
  );
endinterface

// File: rtl/btb_predict_ctrl.sv
// Branch prediction controller: zero-latency BTB lookup for fetch, plus a small
// resolution queue drained by read-modify-write updates of the BTB frame.
module btb_predict_ctrl #(
  parameter int IDX_W  = 4,
  parameter int QDEPTH = 2
) (
  input  logic                CLK,
  input  logic                RST,
  btb_predict_ctrl_if.tb      btbif,
  input  logic [31:0]         fetch_pc,
  input  logic                fetch_en,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic                stall_fetch,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [31:0]         res_pc,
  input  logic [31:0]         res_target,
  input  logic                res_taken
);
  localparam int TAG_W = 30 - IDX_W;
  localparam int FRM_W = 1 + TAG_W + 32 + 2;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(QDEPTH - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [FRM_W-1:0] cap;
  logic [FRM_W-1:0] new_frame;
  logic [1:0]       new_ctr;

  // Queue payload keeps the word address only; byte offset bits never matter.
  logic [29:0]      q_pc  [QDEPTH];
  logic [31:0]      q_tgt [QDEPTH];
  logic             q_tkn [QDEPTH];

  logic [29:0]      head_pc;
  logic [31:0]      head_tgt;
  logic             head_tkn;
  logic             push, pop, stolen, fetch_hit, cap_hit;
  logic             unused_bits;

  assign unused_bits = ^{fetch_pc[1:0], res_pc[1:0]};

  assign head_pc   = q_pc[rd_ptr];
  assign head_tgt  = q_tgt[rd_ptr];
  assign head_tkn  = q_tkn[rd_ptr];

  assign res_ready   = (count < FULL);
  assign push        = res_valid && res_ready;
  assign pop         = (state == WR);
  assign stall_fetch = (state == RD) && (count == FULL);
  assign stolen      = (state == RD) && (!fetch_en || count == FULL);

  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CNT_W'(1);
    else if (pop && !push)
      count_nx = count - CNT_W'(1);
  end

  // Fetch lookup; suppressed whenever the update path owns the read port.
  assign btbif.rsel  = stolen ? head_pc[IDX_W-1:0] : fetch_pc[IDX_W+1:2];
  assign fetch_hit   = btbif.rdat[FRM_W-1] &&
                       (btbif.rdat[FRM_W-2 -: TAG_W] == fetch_pc[31:IDX_W+2]);
  assign pred_taken  = !stolen && fetch_hit && btbif.rdat[1];
  assign pred_target = btbif.rdat[33:2];
  assign btbif.phit  = !stolen && fetch_hit && fetch_en;

  assign cap_hit = cap[FRM_W-1] && (cap[FRM_W-2 -: TAG_W] == head_pc[29:IDX_W]);

  always_comb begin
    new_ctr = cap[1:0];
    if (head_tkn)
      new_ctr = (cap[1:0] == 2'b11) ? 2'b11 : cap[1:0] + 2'd1;
    else
      new_ctr = (cap[1:0] == 2'b00) ? 2'b00 : cap[1:0] - 2'd1;
    if (cap_hit)
      new_frame = {1'b1, cap[FRM_W-2 -: TAG_W], head_tkn ? head_tgt : cap[33:2], new_ctr};
    else
      new_frame = {1'b1, head_pc[29:IDX_W], head_tgt, 2'b10};
  end

  always_comb begin
    state_nx   = state;
    btbif.wen  = 1'b0;
    btbif.wsel = head_pc[IDX_W-1:0];
    btbif.wdat = new_frame;
    case (state)
      IDLE: if (count != '0) state_nx = RD;
      RD:   if (stolen) state_nx = WR;
      WR: begin
        // A not-taken miss is dropped without allocating an entry.
        btbif.wen = cap_hit || head_tkn;
        state_nx  = (count_nx != '0) ? RD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cap    <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (stolen) cap <= btbif.rdat;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr]  <= res_pc[31:2];
      q_tgt[wr_ptr] <= res_target;
      q_tkn[wr_ptr] <= res_taken;
    end
  end
endmodule
